// File: rtl/full_sub_pkg.sv
// Shared arithmetic constants for the registered ripple-borrow subtractor.
package full_sub_pkg;

   localparam int   FULL_SUB_WIDTH = 1;
   localparam logic D_RST_BIT      = 1'b0;

endpackage

// File: rtl/full_sub_cell.sv
// Combinational 1-bit full-subtractor cell; one link of the borrow chain.
module full_sub_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/full_sub.sv
// Registered WIDTH-bit ripple-borrow subtractor: {bo, d} = a - b - c, one-cycle latency.
module full_sub
   import full_sub_pkg::*;
#(
   parameter int WIDTH = FULL_SUB_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   output logic             out_valid,
   output logic [WIDTH-1:0] d,
   output logic             bo
);

   logic [WIDTH:0]   br;
   logic [WIDTH-1:0] d_next;

   assign br[0] = c;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_sub_cell u_cell (
         .a    (a[i]),
         .b    (b[i]),
         .bin  (br[i]),
         .d    (d_next[i]),
         .bout (br[i+1])
      );
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         d         <= {WIDTH{D_RST_BIT}};
         bo        <= 1'b0;
      end else begin
         out_valid <= in_valid;
         // Result registers only load on valid operands, so idle inputs never disturb d/bo.
         if (in_valid) begin
            d  <= d_next;
            bo <= br[WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_full_sub.sv
// Scoreboard bench for full_sub at WIDTH=1 (truth table) and WIDTH=8 (arithmetic model).
module tb_full_sub;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       c = 1'b0;

   logic       ov1, d1, bo1;
   logic       ov8, bo8;
   logic [7:0] d8;

   logic [7:0] tt_d  = 8'b1001_0110;
   logic [7:0] tt_bo = 8'b1000_1110;

   logic [1:0] q1[$];
   logic [8:0] q8[$];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   full_sub #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .a(a8[0]), .b(b8[0]), .c(c),
      .out_valid(ov1), .d(d1), .bo(bo1)
   );

   full_sub #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .a(a8), .b(b8), .c(c),
      .out_valid(ov8), .d(d8), .bo(bo8)
   );

   task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Apply operands for the next edge; queue the expected results when they will be accepted.
   task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic cv);
      logic [2:0] idx;
      logic [8:0] r;
      in_valid = v;
      a8 = av;
      b8 = bv;
      c  = cv;
      if (v && !rst) begin
         idx = {av[0], bv[0], cv};
         q1.push_back({tt_bo[idx], tt_d[idx]});
         r = {1'b0, av} - {1'b0, bv} - {8'd0, cv};
         q8.push_back(r);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic v, input logic [7:0] dv, input logic bv);
      check({tag, "_w1"}, {ov1, bo1, d1}, {v, bv, dv[0]});
      check({tag, "_w8"}, {ov8, bo8, d8}, {v, bv, dv});
   endtask

   always @(negedge clk) begin
      if (ov1) begin
         if (q1.size() == 0) check("w1_unexpected_valid", ov1, 1'b0);
         else check("w1_result", {bo1, d1}, q1.pop_front());
      end
      if (ov8) begin
         if (q8.size() == 0) check("w8_unexpected_valid", ov8, 1'b0);
         else check("w8_result", {bo8, d8}, q8.pop_front());
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_state("reset_state", 1'b0, 8'h00, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         logic [2:0] abc;
         abc = 3'(i);
         drive(1'b1, {7'd0, abc[2]}, {7'd0, abc[1]}, abc[0]);
      end

      drive(1'b1, 8'h00, 8'hFF, 1'b1);
      drive(1'b1, 8'h80, 8'h01, 1'b0);
      drive(1'b1, 8'h05, 8'h05, 1'b1);
      drive(1'b1, 8'hFF, 8'h00, 1'b0);
      drive(1'b1, 8'h3C, 8'h3C, 1'b0);

      // Reset one edge after a valid 1,1,1 operation.
      drive(1'b1, 8'h01, 8'h01, 1'b1);
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_state("mid_reset", 1'b0, 8'h00, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_state("post_reset", 1'b0, 8'h00, 1'b0);

      drive(1'b1, 8'h01, 8'h00, 1'b0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
         @(negedge clk);
         check_state("hold", 1'b0, 8'h01, 1'b0);
      end

      rst = 1'b1;
      drive(1'b1, 8'h00, 8'h01, 1'b1);
      @(negedge clk);
      check_state("rst_over_valid", 1'b0, 8'h00, 1'b0);
      rst = 1'b0;

      for (int n = 0; n < 1000; n++)
         drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      check("w1_queue_drained", 10'(q1.size()), 10'd0);
      check("w8_queue_drained", 10'(q8.size()), 10'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/full_sub.md
Name: full_sub

Overview:
- Registered full subtractor: computes Difference and Borrow-out from Minuend, Subtrahend and Borrow-in.
- Generalised to a WIDTH-bit ripple-borrow subtractor. WIDTH=1 is the classic 1-bit full subtractor, and the 1-bit truth table is the golden reference.
- Used as a datapath primitive inside arithmetic units. The Borrow-out can chain into a more-significant instance's Borrow-in, one cycle later.

Parameters:
- WIDTH, 1, operand/difference width in bits (must be >= 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b/c are valid this cycle.
- a  input  WIDTH  minuend (unsigned).
- b  input  WIDTH  subtrahend (unsigned).
- c  input  1  borrow-in.
- out_valid  output  1  d/bo hold a new result this cycle.
- d  output  WIDTH  difference.
- bo  output  1  borrow-out.

Behaviour:
- Arithmetic: {bo, d} = ({1'b0,a} - {1'b0,b} - c) mod 2^(WIDTH+1).
  - d is the low WIDTH bits.
  - bo=1 iff a < b + c (unsigned compare).
- Per bit i, with borrow chain br[0]=c:
  - d[i] = a[i] ^ b[i] ^ br[i]
  - br[i+1] = (~a[i] & b[i]) | (~a[i] & br[i]) | (b[i] & br[i])
  - bo = br[WIDTH]
- WIDTH=1 truth table (a b c -> d bo): 000->0 0, 001->1 1, 010->1 1, 011->0 1, 100->1 0, 101->0 0, 110->0 0, 111->1 1.
- Latency: exactly 1 cycle. Operands sampled at edge N with in_valid=1 appear on d/bo with out_valid=1 after edge N.
- Throughput: one operation per cycle; no backpressure, no ready signal.
- in_valid=0 at an edge:
  - out_valid goes 0.
  - d/bo hold their previous values, not recomputed.
- Reset (rst=1 at an edge): d=0, bo=0, out_valid=0. Reset has priority over in_valid on the same edge.
- Reset mid-stream: the in-flight result is discarded.
  - out_valid stays 0 for the first cycle after rst deasserts.
  - Normal operation resumes with the first in_valid sampled while rst=0.
- Boundaries:
  - a=b with c=0 -> d=0, bo=0.
  - a=0 with b=all-ones and c=1 -> d=0, bo=1 (full wrap).
  - a=all-ones with b=0 and c=0 -> d=all-ones, bo=0.
- No X propagation from a/b/c when in_valid=0: the registers do not load.

Decomposition:
- Shared package: no typedefs needed. WIDTH default and a localparam for the reset value of d (all-zero) may live in the team arithmetic package.
- One sub-module: full_sub_cell, a purely combinational 1-bit cell (a, b, bin -> d, bout) using the equations above. It is instantiated WIDTH times via generate to form the borrow chain.
- The top level holds only the output registers and the valid flop.

Test Plan:
- WIDTH=1: apply all 8 (a,b,c) combinations in order 000..111, one every cycle with in_valid=1. Each result appears one cycle later and matches the truth table above (d sequence 0,1,1,0,1,0,0,1; bo sequence 0,1,1,1,0,0,0,1).
- Reset: drive 1,1,1 with in_valid=1, then assert rst on the next edge. Required: d=0, bo=0, out_valid=0. out_valid stays 0 one cycle after rst drops.
- Hold: result a=1,b=0,c=0 (d=1,bo=0), then in_valid=0 for 3 cycles. Required: out_valid=0 and d/bo remain 1/0.
- Simultaneous rst and in_valid (a=0,b=1,c=1): reset wins, giving d=0, bo=0, out_valid=0.
- WIDTH=8: a=0x00, b=0xFF, c=1 -> d=0x00, bo=1; a=0x80, b=0x01, c=0 -> d=0x7F, bo=0; a=0x05, b=0x05, c=1 -> d=0xFF, bo=1.
- WIDTH=8 back-to-back random stream of 1000 ops vs. the reference model {bo,d}=a-b-c, checked with 1-cycle latency every cycle.
